// File: rtl/sha256_w_mem_pipeline_ctrl.sv
// Elastic valid/ready scheduler for the SHA256 message-expansion stage chain.
// Produces per-stage write enables, per-stage occupancy and block counters.
module sha256_w_mem_pipeline_ctrl #(
  parameter int NUM_STAGES = 48,
  parameter int CNT_W      = 32,
  localparam int IFW       = $clog2(NUM_STAGES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [IFW-1:0]        in_flight,
  output logic [CNT_W-1:0]      done_cnt,
  output logic                  busy
);

  logic [NUM_STAGES-1:0] valid_reg;
  logic [NUM_STAGES-1:0] drain;
  logic [NUM_STAGES-1:0] src;
  logic [IFW-1:0]        in_flight_reg;
  logic [CNT_W-1:0]      done_cnt_reg;
  logic                  hold;
  logic                  accept;
  logic                  deliver;

  // Reset and flush both freeze the chain: no enables, no input acceptance.
  assign hold = flush | ~RST;
  assign src  = {valid_reg[NUM_STAGES-2:0], in_valid};

  // Drain terms ripple from the output back toward the input, so a stage
  // can refill in the same cycle its occupant moves on.
  always_comb begin
    logic en_above;
    drain    = '0;
    stage_en = '0;
    drain[NUM_STAGES-1]    = ~valid_reg[NUM_STAGES-1] | out_ready;
    stage_en[NUM_STAGES-1] = src[NUM_STAGES-1] & drain[NUM_STAGES-1] & ~hold;
    en_above = stage_en[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      drain[i]    = ~valid_reg[i] | en_above;
      stage_en[i] = src[i] & drain[i] & ~hold;
      en_above    = stage_en[i];
    end
  end

  assign in_ready  = drain[0] & ~hold;
  assign out_valid = valid_reg[NUM_STAGES-1];
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready & ~flush;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_reg     <= '0;
      in_flight_reg <= '0;
      done_cnt_reg  <= '0;
    end else if (flush) begin
      valid_reg     <= '0;
      in_flight_reg <= '0;
    end else begin
      valid_reg <= stage_en | (valid_reg & ~drain);
      if (accept && !deliver) begin
        in_flight_reg <= in_flight_reg + IFW'(1);
      end else if (deliver && !accept) begin
        in_flight_reg <= in_flight_reg - IFW'(1);
      end
      if (deliver) begin
        done_cnt_reg <= done_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stage_valid = valid_reg;
  assign in_flight   = in_flight_reg;
  assign done_cnt    = done_cnt_reg;
  assign busy        = (in_flight_reg != '0);

endmodule

// File: tb/tb_sha256_w_mem_pipeline_ctrl.sv
// Directed bench for the expansion-chain scheduler; a tag shadow pipeline
// moved by stage_en checks block order at the output.
module tb_sha256_w_mem_pipeline_ctrl;
  localparam int N     = 48;
  localparam int CNT_W = 32;
  localparam int IFW   = $clog2(N + 1);

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic [N-1:0]   stage_en;
  logic [N-1:0]   stage_valid;
  logic [IFW-1:0] in_flight;
  logic [CNT_W-1:0] done_cnt;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int tag_pipe [N];
  int in_tag = 0;
  int next_tag = 0;
  int exp_tag = 0;

  sha256_w_mem_pipeline_ctrl #(.NUM_STAGES(N), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .stage_en(stage_en), .stage_valid(stage_valid),
    .in_flight(in_flight), .done_cnt(done_cnt), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Shadow datapath: each stage captures its predecessor's tag when enabled.
  always @(posedge CLK) begin
    if (stage_en[0]) tag_pipe[0] <= in_tag;
    for (int i = 1; i < N; i++) begin
      if (stage_en[i]) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic advance();
    if (out_valid && out_ready && !flush) begin
      chk("order", 64'(tag_pipe[N-1]), 64'(exp_tag));
      exp_tag++;
    end
    if (in_valid && in_ready) next_tag++;
    @(posedge CLK);
    #1;
    in_tag = next_tag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] e;
    int acc;

    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stage_en", 64'(stage_en), 64'd0);
    chk("rst_in_flight", 64'(in_flight), 64'd0);
    chk("rst_done", 64'(done_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    #5 RST = 1'b1;
    @(posedge CLK); #1;

    for (int k = 0; k < 5; k++) begin
      settle();
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_stage_en", 64'(stage_en), 64'd0);
      chk("idle_in_flight", 64'(in_flight), 64'd0);
      chk("idle_done", 64'(done_cnt), 64'd0);
      advance();
    end

    // Single block: enable walks one stage per cycle, out_valid after N cycles.
    in_valid = 1'b1; out_ready = 1'b1;
    settle();
    chk("single_en0", 64'(stage_en), 64'd1);
    advance();
    in_valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      settle();
      e = '0;
      if (i < N) e[i] = 1'b1;
      chk("single_en", 64'(stage_en), 64'(e));
      chk("single_out_valid", 64'(out_valid), 64'(i == N));
      if (i == 24) chk("single_in_flight", 64'(in_flight), 64'd1);
      advance();
    end
    settle();
    chk("single_in_flight_end", 64'(in_flight), 64'd0);
    chk("single_done", 64'(done_cnt), 64'd1);
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_out_valid_end", 64'(out_valid), 64'd0);
    advance();

    // 100 back-to-back blocks at full throughput.
    out_ready = 1'b1;
    for (int k = 0; k < 148; k++) begin
      in_valid = (k < 100);
      settle();
      if (k < 100) chk("b2b_in_ready", 64'(in_ready), 64'd1);
      chk("b2b_out_valid", 64'(out_valid), 64'(k >= N));
      if (k == 100) chk("b2b_in_flight", 64'(in_flight), 64'd48);
      advance();
    end
    in_valid = 1'b0;
    settle();
    chk("b2b_done", 64'(done_cnt), 64'd101);
    chk("b2b_in_flight_end", 64'(in_flight), 64'd0);
    advance();

    // Output stalled, input streaming: fills exactly N stages.
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int k = 0; k < 60; k++) begin
      settle();
      if (in_ready) acc++;
      advance();
    end
    settle();
    chk("stall_accepts", 64'(acc), 64'd48);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_in_flight", 64'(in_flight), 64'd48);
    chk("stall_valid", 64'(stage_valid), 64'hFFFF_FFFF_FFFF);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    advance();
    out_ready = 1'b1;
    settle();
    chk("full_in_ready", 64'(in_ready), 64'd1);
    chk("full_stage_en", 64'(stage_en), 64'hFFFF_FFFF_FFFF);
    advance();
    out_ready = 1'b0;
    settle();
    chk("full_in_flight", 64'(in_flight), 64'd48);
    chk("full_done", 64'(done_cnt), 64'd102);
    chk("full_in_ready_after", 64'(in_ready), 64'd0);
    advance();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      settle();
      chk("drain_out_valid", 64'(out_valid), 64'd1);
      advance();
    end
    settle();
    chk("drain_in_flight", 64'(in_flight), 64'd0);
    chk("drain_done", 64'(done_cnt), 64'd150);
    advance();

    // Gapped arrivals with stalled output collapse to the top of the chain.
    out_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      settle();
      chk("gap_in_ready", 64'(in_ready), 64'd1);
      advance();
      in_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
        settle();
        advance();
      end
    end
    for (int k = 0; k < 60; k++) begin
      settle();
      advance();
    end
    settle();
    e = '0;
    for (int i = 43; i < N; i++) e[i] = 1'b1;
    chk("gap_valid", 64'(stage_valid), 64'(e));
    chk("gap_in_flight", 64'(in_flight), 64'd5);
    chk("gap_in_ready_after", 64'(in_ready), 64'd1);
    advance();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("gap_out_valid", 64'(out_valid), 64'd1);
      advance();
    end
    settle();
    chk("gap_in_flight_end", 64'(in_flight), 64'd0);
    chk("gap_done", 64'(done_cnt), 64'd155);
    advance();

    // Flush with 20 blocks stacked at the output.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      settle();
      advance();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      settle();
      advance();
    end
    settle();
    chk("pre_flush_in_flight", 64'(in_flight), 64'd20);
    chk("pre_flush_out_valid", 64'(out_valid), 64'd1);
    advance();
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    settle();
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_stage_en", 64'(stage_en), 64'd0);
    advance();
    flush = 1'b0; in_valid = 1'b0;
    settle();
    chk("flush_in_flight", 64'(in_flight), 64'd0);
    chk("flush_valid", 64'(stage_valid), 64'd0);
    chk("flush_done", 64'(done_cnt), 64'd155);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    exp_tag = next_tag;
    advance();

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      advance();
    end
    settle();
    chk("pre_rst_in_flight", 64'(in_flight), 64'd10);
    RST = 1'b0;
    #1;
    chk("arst_in_flight", 64'(in_flight), 64'd0);
    chk("arst_valid", 64'(stage_valid), 64'd0);
    chk("arst_done", 64'(done_cnt), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_stage_en", 64'(stage_en), 64'd0);
    #2;
    RST = 1'b1; in_valid = 1'b0;
    @(posedge CLK); #1;
    exp_tag = next_tag; in_tag = next_tag;
    settle();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_in_flight", 64'(in_flight), 64'd0);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
